// File: rtl/con_ff_multi.sv
// Branch-condition unit: evaluates signed/unsigned conditions against zero or a
// latched operand A, writes a selectable flag and counts taken results.
module con_ff_multi #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COND_LSB   = 19,
  parameter int unsigned NUM_FLAGS  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [31:0]                  instruction,
  input  logic [DATA_WIDTH-1:0]        bus,
  input  logic                         OPAin,
  input  logic                         CONin,
  input  logic [$clog2(NUM_FLAGS)-1:0] flag_sel,
  output logic                         out,
  output logic [NUM_FLAGS-1:0]         flags,
  output logic                         cmp_valid,
  output logic                         err_no_opa,
  output logic [CNT_WIDTH-1:0]         taken_count
);

  localparam int unsigned COND_W = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    A_HELD = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    REL_EQ     = 3'b000,
    REL_NE     = 3'b001,
    REL_GE     = 3'b010,
    REL_LT     = 3'b011,
    REL_GT     = 3'b100,
    REL_LE     = 3'b101,
    REL_ALWAYS = 3'b110,
    REL_NEVER  = 3'b111
  } rel_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [NUM_FLAGS-1:0]  flags_q, flags_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  cmp_valid_q, cmp_valid_d;
  logic                  err_q, err_d;

  logic [COND_W-1:0]     cond;
  logic                  is_unsigned;
  logic                  use_opa;
  rel_t                  rel;
  logic [DATA_WIDTH-1:0] rhs;
  logic                  rel_eq;
  logic                  rel_lt;
  logic                  rel_result;
  logic                  no_opa;
  logic                  wr_val;
  logic                  unused_instr;

  assign cond        = instruction[COND_LSB +: COND_W];
  assign is_unsigned = cond[4];
  assign use_opa     = cond[3];
  assign rel         = rel_t'(cond[2:0]);
  assign unused_instr = ^instruction;

  // Relation core: everything is derived from equality and less-than of bus vs rhs.
  always_comb begin
    rhs        = use_opa ? opa_q : '0;
    rel_eq     = (bus == rhs);
    rel_lt     = is_unsigned ? (bus < rhs) : ($signed(bus) < $signed(rhs));
    rel_result = 1'b0;
    unique case (rel)
      REL_EQ:     rel_result = rel_eq;
      REL_NE:     rel_result = !rel_eq;
      REL_GE:     rel_result = !rel_lt;
      REL_LT:     rel_result = rel_lt;
      REL_GT:     rel_result = !rel_lt && !rel_eq;
      REL_LE:     rel_result = rel_lt || rel_eq;
      REL_ALWAYS: rel_result = 1'b1;
      REL_NEVER:  rel_result = 1'b0;
      default:    rel_result = 1'b0;
    endcase
  end

  // An operand-A compare with no A held forces a 0 result and flags an error.
  assign no_opa = CONin && use_opa && (state_q == IDLE);
  assign wr_val = no_opa ? 1'b0 : rel_result;

  // Next-state, operand, flag, counter and pulse logic.
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    cmp_valid_d = 1'b0;
    err_d       = 1'b0;

    if (CONin) begin
      flags_d[flag_sel] = wr_val;
      cmp_valid_d       = 1'b1;
      err_d             = no_opa;
      if (wr_val && (cnt_q != {CNT_WIDTH{1'b1}})) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (OPAin) begin
          state_d = A_HELD;
        end
      end
      A_HELD: begin
        // A is consumed by an operand compare unless it is reloaded in the same cycle.
        if (OPAin) begin
          state_d = A_HELD;
        end else if (CONin && use_opa) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (OPAin) begin
      opa_d = bus;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      cmp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
      cmp_valid_q <= cmp_valid_d;
      err_q       <= err_d;
    end
  end

  assign out         = flags_q[flag_sel];
  assign flags       = flags_q;
  assign cmp_valid   = cmp_valid_q;
  assign err_no_opa  = err_q;
  assign taken_count = cnt_q;

endmodule

// File: tb/tb_con_ff_multi.sv
// Directed self-checking bench for con_ff_multi; a CNT_WIDTH=4 copy shares the
// stimulus to exercise counter saturation.
module tb_con_ff_multi;

  logic        clk;
  logic        clr;
  logic [31:0] instruction;
  logic [31:0] bus;
  logic        OPAin;
  logic        CONin;
  logic [1:0]  flag_sel;

  logic        out;
  logic [3:0]  flags;
  logic        cmp_valid;
  logic        err_no_opa;
  logic [15:0] taken_count;

  logic        out4;
  logic [3:0]  flags4;
  logic        cmp_valid4;
  logic        err_no_opa4;
  logic [3:0]  taken_count4;

  int n_checks;
  int n_errors;

  con_ff_multi dut (
    .clk         (clk),
    .clr         (clr),
    .instruction (instruction),
    .bus         (bus),
    .OPAin       (OPAin),
    .CONin       (CONin),
    .flag_sel    (flag_sel),
    .out         (out),
    .flags       (flags),
    .cmp_valid   (cmp_valid),
    .err_no_opa  (err_no_opa),
    .taken_count (taken_count)
  );

  con_ff_multi #(.CNT_WIDTH(4)) dut4 (
    .clk         (clk),
    .clr         (clr),
    .instruction (instruction),
    .bus         (bus),
    .OPAin       (OPAin),
    .CONin       (CONin),
    .flag_sel    (flag_sel),
    .out         (out4),
    .flags       (flags4),
    .cmp_valid   (cmp_valid4),
    .err_no_opa  (err_no_opa4),
    .taken_count (taken_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus and advance past the rising edge.
  task automatic drive(input logic [4:0] c, input logic [31:0] b, input logic [1:0] sel,
                       input logic opa, input logic con);
    instruction = 32'(c) << 19;
    bus         = b;
    flag_sel    = sel;
    OPAin       = opa;
    CONin       = con;
    tick();
  endtask

  task automatic idle_cycle();
    OPAin = 1'b0;
    CONin = 1'b0;
    tick();
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    clr         = 1'b0;
    instruction = '0;
    bus         = '0;
    OPAin       = 1'b0;
    CONin       = 1'b0;
    flag_sel    = '0;
    tick();
    tick();
    clr = 1'b1;

    // Activity before reset: always-true into flag 3, then latch an operand.
    drive(5'b00110, 32'h0, 2'd3, 1'b0, 1'b1);
    check("pre_flags", 32'(flags), 32'h8);
    check("pre_cnt", 32'(taken_count), 32'd1);
    drive(5'b00110, 32'h9, 2'd3, 1'b1, 1'b0);
    clr = 1'b0;
    idle_cycle();
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_cnt", 32'(taken_count), 32'd0);
    check("rst_valid", 32'(cmp_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    clr = 1'b1;

    // Signed lt vs zero: -1 < 0 is true.
    drive(5'b00011, 32'hFFFF_FFFF, 2'd2, 1'b0, 1'b1);
    check("slt0_flags", 32'(flags), 32'h4);
    check("slt0_valid", 32'(cmp_valid), 32'd1);
    check("slt0_err", 32'(err_no_opa), 32'd0);
    check("slt0_cnt", 32'(taken_count), 32'd1);
    check("slt0_out", 32'(out), 32'd1);
    idle_cycle();
    check("valid_drop", 32'(cmp_valid), 32'd0);
    // Unsigned lt vs zero is never true.
    drive(5'b10011, 32'hFFFF_FFFF, 2'd2, 1'b0, 1'b1);
    check("ult0_flags", 32'(flags), 32'h0);
    check("ult0_cnt", 32'(taken_count), 32'd1);

    // Operand compare 7 > 5, then a second one with A already consumed.
    drive(5'b00000, 32'd5, 2'd1, 1'b1, 1'b0);
    drive(5'b01100, 32'd7, 2'd1, 1'b0, 1'b1);
    check("gtA_flags", 32'(flags), 32'h2);
    check("gtA_err", 32'(err_no_opa), 32'd0);
    check("gtA_cnt", 32'(taken_count), 32'd2);
    drive(5'b01100, 32'd7, 2'd1, 1'b0, 1'b1);
    check("noA_err", 32'(err_no_opa), 32'd1);
    check("noA_valid", 32'(cmp_valid), 32'd1);
    check("noA_flags", 32'(flags), 32'h0);
    check("noA_cnt", 32'(taken_count), 32'd2);

    // Simultaneous load and compare uses the old A, then the new A stays held.
    drive(5'b00000, 32'd3, 2'd0, 1'b1, 1'b0);
    drive(5'b01000, 32'd3, 2'd0, 1'b1, 1'b1);
    check("sim_flags", 32'(flags), 32'h1);
    check("sim_err", 32'(err_no_opa), 32'd0);
    check("sim_cnt", 32'(taken_count), 32'd3);
    drive(5'b01000, 32'd4, 2'd0, 1'b0, 1'b1);
    check("sim2_flags", 32'(flags), 32'h0);
    check("sim2_err", 32'(err_no_opa), 32'd0);
    check("sim2_cnt", 32'(taken_count), 32'd3);

    // Unsigned ge vs A: 0xFFFFFFFF >= 5 unsigned.
    drive(5'b00000, 32'd5, 2'd3, 1'b1, 1'b0);
    drive(5'b11010, 32'hFFFF_FFFF, 2'd3, 1'b0, 1'b1);
    check("ugeA_flags", 32'(flags), 32'h8);
    // Signed ge vs A: -1 >= 5 is false.
    drive(5'b00000, 32'd5, 2'd3, 1'b1, 1'b0);
    drive(5'b01010, 32'hFFFF_FFFF, 2'd3, 1'b0, 1'b1);
    check("sgeA_flags", 32'(flags), 32'h0);
    check("geA_cnt", 32'(taken_count), 32'd4);
    // Unsigned ge vs zero always true; signed le 0 <= 0; never code clears.
    drive(5'b10010, 32'h0, 2'd2, 1'b0, 1'b1);
    check("uge0_flags", 32'(flags), 32'h4);
    drive(5'b00101, 32'h0, 2'd1, 1'b0, 1'b1);
    check("sle0_flags", 32'(flags), 32'h6);
    drive(5'b00100, 32'h0, 2'd1, 1'b0, 1'b1);
    check("sgt0_flags", 32'(flags), 32'h4);
    drive(5'b00111, 32'h0, 2'd2, 1'b0, 1'b1);
    check("never_flags", 32'(flags), 32'h0);
    check("mix_cnt", 32'(taken_count), 32'd6);

    // Reset in the same cycle as a valid operand compare.
    drive(5'b01000, 32'd8, 2'd1, 1'b1, 1'b0);
    drive(5'b00110, 32'd0, 2'd3, 1'b0, 1'b1);
    check("pre2_flags", 32'(flags), 32'h8);
    clr = 1'b0;
    drive(5'b01000, 32'd8, 2'd1, 1'b0, 1'b1);
    check("rmid_flags", 32'(flags), 32'h0);
    check("rmid_valid", 32'(cmp_valid), 32'd0);
    check("rmid_cnt", 32'(taken_count), 32'd0);
    clr = 1'b1;
    drive(5'b01000, 32'd8, 2'd1, 1'b0, 1'b1);
    check("rmid_err", 32'(err_no_opa), 32'd1);
    check("rmid_flag1", 32'(out), 32'd0);

    // Counter saturation on the 4-bit copy.
    clr = 1'b0;
    idle_cycle();
    clr = 1'b1;
    check("sat_start", 32'(taken_count4), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(5'b00110, 32'h0, 2'd0, 1'b0, 1'b1);
    end
    idle_cycle();
    check("sat_cnt4", 32'(taken_count4), 32'd15);
    check("sat_cnt16", 32'(taken_count), 32'd20);
    check("sat_flags4", 32'(flags4), 32'h1);
    check("sat_valid4", 32'(cmp_valid4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
